uart_rx_configurable: RTL and testbench
=======================================

UART_RX_CONFIGURABLE -- requirements
Module: uart_rx_configurable

Interface
REQ-001 The block SHALL expose parameter DATA_BITS, default 8, number of data bits per frame (legal 5..9).
REQ-002 The block SHALL expose parameter OVERSAMPLE, default 16, clk ticks per baud interval (even, legal 8..64).
REQ-003 The block SHALL expose parameter PARITY, default 0, parity mode (0 none, 1 even, 2 odd).
REQ-004 The block SHALL expose parameter STOP_BITS, default 1, stop bits checked per frame (legal 1 or 2).
REQ-005 The block SHALL have port clk, input, 1, rx sampling clock at OVERSAMPLE x baud.
REQ-006 The block SHALL have port reset, input, 1, reset; one clock, reset synchronous and active-high.
REQ-007 The block SHALL have port en, input, 1, receive enable.
REQ-008 The block SHALL have port in, input, 1, asynchronous serial rx line (idle high).
REQ-009 The block SHALL have port busy, output, 1, frame reception in progress.
REQ-010 The block SHALL have port valid, output, 1, data holding register is full.
REQ-011 The block SHALL have port ready, input, 1, consumer accepts data when valid && ready.
REQ-012 The block SHALL have port data, output, DATA_BITS, received data, LSB = first bit received.
REQ-013 The block SHALL have port frame_err, output, 1, stop-bit error flag, qualified by valid.
REQ-014 The block SHALL have port parity_err, output, 1, parity mismatch flag, qualified by valid; constant 0 when PARITY=0.
REQ-015 The block SHALL have port overrun, output, 1, one-cycle pulse when a completed frame is dropped.

Function
REQ-016 in SHALL pass through a 2-flop synchroniser; all logic SHALL use only the second-flop output (in_s).
REQ-017 State machine SHALL have states IDLE, START, DATA, PARITY, STOP; tick counter width SHALL be clog2(OVERSAMPLE)+1.
REQ-018 IDLE: first cycle in_s=0 SHALL start count=1 and enter START; busy stays 0.
REQ-019 START: if in_s=1 before count reaches OVERSAMPLE/2, SHALL return to IDLE silently (false start, no flag); at count=OVERSAMPLE/2 with in_s=0, SHALL set busy=1, reset count, enter DATA.
REQ-020 DATA: SHALL sample in_s every OVERSAMPLE ticks (bit mid-points), shifting LSB-first; after DATA_BITS samples SHALL enter PARITY if PARITY!=0, else STOP.
REQ-021 PARITY: one sample OVERSAMPLE ticks later; even mode error if XOR(data,parity bit)=1, odd mode error if XOR=0.
REQ-022 STOP: STOP_BITS samples at OVERSAMPLE-tick spacing; any sample 0 SHALL set frame_err for this frame; after last stop sample SHALL go to IDLE with busy=0 the next cycle (back-to-back start detectable immediately).
REQ-023 Completion: the cycle after the last stop sample, data/frame_err/parity_err SHALL load and valid=1 (latency 1 clk) when valid=0 or ready=1 in that cycle.
REQ-024 valid && ready with no completion SHALL clear valid next cycle; data/error outputs hold until next load.
REQ-025 Completion while valid=1 and ready=0 SHALL drop the new frame, keep held data, and pulse overrun for exactly 1 cycle.
REQ-026 Completion while valid=1 and ready=1 SHALL load the new frame with valid remaining 1, no overrun.
REQ-027 en=0 SHALL force IDLE and busy=0 next cycle, discarding any partial frame; holding register and valid SHALL be unaffected; ready handshake still works.
REQ-028 Line held low in IDLE after a frame (break) SHALL NOT retrigger until in_s has been 1 for at least one cycle.

Reset
REQ-029 reset=1 SHALL, at the next clk edge, set state IDLE, counters 0, synchroniser flops 1, busy=0, valid=0, data=0, frame_err=0, parity_err=0, overrun=0; reset SHALL take priority over en and mid-frame activity.

Verification
REQ-030 Defaults, frame 0x55 with 1 stop bit -> valid=1 with data=0x55, errors 0, valid 1 clk after last stop sample.
REQ-031 PARITY=1, DATA_BITS=7, frame 0x41 with parity bit 1 -> data=0x41, parity_err=1; with parity bit 0 -> parity_err=0.
REQ-032 STOP_BITS=2, second stop bit driven 0 -> frame_err=1, data still loaded.
REQ-033 Two back-to-back frames 0xA5, 0x3C with ready=0 -> data=0xA5 held, overrun pulses 1 cycle; repeat with ready=1 at completion -> data=0x3C, no overrun.
REQ-034 Low glitch of OVERSAMPLE/2-1 ticks in IDLE -> busy stays 0, valid stays 0, no flags.
REQ-035 en=0 mid-DATA then valid frame 0x0F -> partial frame discarded, busy=0 next cycle, then data=0x0F received; reset mid-frame -> all outputs 0.

Source files
------------

// File: rtl/uart_rx_configurable.sv
// uart_rx_configurable: oversampled UART receiver with optional parity, stop-bit checks
// and a one-entry holding register with valid/ready handshake and overrun pulse.
module uart_rx_configurable #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 in,
  output logic                 busy,
  output logic                 valid,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);
  localparam int CW = $clog2(OVERSAMPLE) + 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t state_q, state_d;
  logic sync_q, in_s_q, armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic perr_q, perr_d, ferr_q, ferr_d, busy_q, busy_d, valid_q, valid_d;
  logic frame_err_q, frame_err_d, parity_err_q, parity_err_d, overrun_q, overrun_d;
  logic tick, done, load;
  always_comb begin
    tick = cnt_q == FULL;
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    busy_d = busy_q;
    done = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!in_s_q && armed_q) begin
          state_d = S_START;
          cnt_d = CW'(1);
        end
      end
      S_START:
        if (in_s_q) state_d = S_IDLE;
        else if (cnt_q == HALF) begin
          state_d = S_DATA;
          cnt_d = '0;
          bit_d = '0;
          busy_d = 1'b1;
          perr_d = 1'b0;
          ferr_d = 1'b0;
        end
      S_DATA:
        if (tick) begin
          cnt_d = '0;
          shift_d = {in_s_q, shift_q[DATA_BITS-1:1]};
          bit_d = bit_q == LAST_DATA ? '0 : bit_q + 1'b1;
          if (bit_q == LAST_DATA) state_d = PARITY != 0 ? S_PARITY : S_STOP;
        end
      S_PARITY:
        if (tick) begin
          cnt_d = '0;
          perr_d = ^shift_q ^ in_s_q ^ (PARITY == 2);
          state_d = S_STOP;
        end
      S_STOP:
        if (tick) begin
          cnt_d = '0;
          ferr_d = ferr_q | ~in_s_q;
          bit_d = bit_q + 1'b1;
          if (bit_q == LAST_STOP) begin
            state_d = S_IDLE;
            busy_d = 1'b0;
            done = 1'b1;
          end
        end
      default: state_d = S_IDLE;
    endcase
    if (!en) begin
      state_d = S_IDLE;
      cnt_d = '0;
      busy_d = 1'b0;
      done = 1'b0;
    end
    // a line still low after a frame (break) must go high before a new start is accepted
    armed_d = in_s_q | (state_q == S_IDLE && armed_q);
    load = done & (~valid_q | ready);
    valid_d = load | (valid_q & ~ready);
    data_d = load ? shift_q : data_q;
    frame_err_d = load ? ferr_d : frame_err_q;
    parity_err_d = load ? perr_q : parity_err_q;
    overrun_d = done & valid_q & ~ready;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 1'b1;
      in_s_q <= 1'b1;
      armed_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
      data_q <= '0;
      frame_err_q <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q <= in;
      in_s_q <= sync_q;
      armed_q <= armed_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      busy_q <= busy_d;
      valid_q <= valid_d;
      data_q <= data_d;
      frame_err_q <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q <= overrun_d;
    end
  end
  assign busy = busy_q;
  assign valid = valid_q;
  assign data = data_q;
  assign frame_err = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_uart_rx_configurable.sv
// tb_uart_rx_configurable: random and directed frames on a default receiver and a
// 7-bit even-parity two-stop-bit receiver, checked against a frame-level model.
module tb_uart_rx_configurable;
  logic clk = 1'b0, reset = 1'b1;
  logic en0 = 1'b1, in0 = 1'b1, ready0 = 1'b0, busy0, valid0, fe0, pe0, ovr0;
  logic [7:0] data0;
  logic en1 = 1'b1, in1 = 1'b1, ready1 = 1'b0, busy1, valid1, fe1, pe1, ovr1;
  logic [6:0] data1;
  int checks = 0, errors = 0, cyc = 0, start_cyc = 0, rise0 = 0, ovr_cnt = 0;
  logic vprev0 = 1'b0, busy_seen = 1'b0;
  logic [7:0] d;
  bit s1, s2, pb;
  always #5 clk = ~clk;
  uart_rx_configurable u_dut0 (.clk(clk), .reset(reset), .en(en0), .in(in0), .busy(busy0),
    .valid(valid0), .ready(ready0), .data(data0), .frame_err(fe0), .parity_err(pe0), .overrun(ovr0));
  uart_rx_configurable #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY(1), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .reset(reset), .en(en1), .in(in1), .busy(busy1), .valid(valid1), .ready(ready1),
    .data(data1), .frame_err(fe1), .parity_err(pe1), .overrun(ovr1));
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (valid0 && !vprev0) rise0 = cyc;
    vprev0 = valid0;
    if (ovr0) ovr_cnt++;
    if (busy0) busy_seen = 1'b1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input bit sel, input bit v, input int n);
    if (sel) in1 = v;
    else in0 = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input bit sel, input logic [7:0] dv, input bit pbit, input bit st1, input bit st2);
    int ov = sel ? 8 : 16;
    int nb = sel ? 7 : 8;
    start_cyc = cyc;
    drive(sel, 1'b0, ov);
    for (int i = 0; i < nb; i++) drive(sel, dv[i], ov);
    if (sel) begin
      drive(sel, pbit, ov);
      drive(sel, st1, ov);
      drive(sel, st2, ov);
    end else drive(sel, st1, ov);
  endtask
  task automatic clear(input bit sel);
    if (sel) ready1 = 1'b1;
    else ready0 = 1'b1;
    @(negedge clk);
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (sel) check("clear1_valid", 32'(valid1), 0);
    else check("clear0_valid", 32'(valid0), 0);
  endtask
  // Frame-level expectations: latency counts posedges from the start-bit drive (2 sync
  // stages, half a bit to mid-start, one bit per sample, one cycle to load).
  task automatic expect0(input string tag, input logic [7:0] dv, input bit fe);
    check({tag, "_valid"}, 32'(valid0), 1);
    check({tag, "_data"}, 32'(data0), 32'(dv));
    check({tag, "_ferr"}, 32'(fe0), 32'(fe));
    check({tag, "_perr"}, 32'(pe0), 0);
    check({tag, "_lat"}, 32'(rise0 - start_cyc), 32'(3 + 8 + 16 * 9));
  endtask
  task automatic expect1(input string tag, input logic [7:0] dv, input bit pbit, input bit fe);
    check({tag, "_valid"}, 32'(valid1), 1);
    check({tag, "_data"}, 32'(data1), 32'(dv[6:0]));
    check({tag, "_perr"}, 32'(pe1), 32'(^dv[6:0] ^ pbit));
    check({tag, "_ferr"}, 32'(fe1), 32'(fe));
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst0_outputs", 32'({busy0, valid0, fe0, pe0, ovr0, data0}), 0);
    check("rst1_outputs", 32'({busy1, valid1, fe1, pe1, ovr1, data1}), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    send(0, 8'h55, 1'b0, 1'b1, 1'b1);
    expect0("f55", 8'h55, 1'b0);
    clear(0);
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      s1 = $urandom_range(0, 3) != 0;
      send(0, d, 1'b0, s1, 1'b1);
      expect0($sformatf("rnd%0d", i), d, !s1);
      clear(0);
      drive(0, 1'b1, 4);
    end
    send(1, 8'h41, 1'b1, 1'b1, 1'b1);
    expect1("par41_p1", 8'h41, 1'b1, 1'b0);
    clear(1);
    drive(1, 1'b1, 4);
    send(1, 8'h41, 1'b0, 1'b1, 1'b1);
    expect1("par41_p0", 8'h41, 1'b0, 1'b0);
    clear(1);
    drive(1, 1'b1, 4);
    send(1, 8'h2A, 1'b1, 1'b1, 1'b0);
    expect1("stop2_low", 8'h2A, 1'b1, 1'b1);
    clear(1);
    drive(1, 1'b1, 4);
    for (int i = 0; i < 6; i++) begin
      d = {1'b0, 7'($urandom)};
      pb = 1'($urandom);
      s1 = $urandom_range(0, 3) != 0;
      s2 = $urandom_range(0, 3) != 0;
      send(1, d, pb, s1, s2);
      expect1($sformatf("prnd%0d", i), d, pb, !(s1 && s2));
      if (i != 5) clear(1);
      drive(1, 1'b1, 4);
    end
    ovr_cnt = 0;
    send(0, 8'hA5, 1'b0, 1'b1, 1'b1);
    send(0, 8'h3C, 1'b0, 1'b1, 1'b1);
    check("ovr_valid", 32'(valid0), 1);
    check("ovr_data_held", 32'(data0), 32'h A5);
    check("ovr_pulse_cycles", 32'(ovr_cnt), 1);
    ovr_cnt = 0;
    fork
      send(0, 8'h3C, 1'b0, 1'b1, 1'b1);
      begin
        repeat (2 + 8 + 16 * 9) @(negedge clk);
        ready0 = 1'b1;
        @(negedge clk);
        ready0 = 1'b0;
        check("rdy_done_valid", 32'(valid0), 1);
        check("rdy_done_data", 32'(data0), 32'h3C);
      end
    join
    check("rdy_done_no_ovr", 32'(ovr_cnt), 0);
    clear(0);
    busy_seen = 1'b0;
    drive(0, 1'b0, 7);
    drive(0, 1'b1, 40);
    check("glitch_busy", 32'(busy_seen), 0);
    check("glitch_outputs", 32'({valid0, fe0, pe0}), 0);
    check("glitch_ovr", 32'(ovr_cnt), 0);
    fork
      send(0, 8'hF0, 1'b0, 1'b1, 1'b1);
      begin
        repeat (60) @(negedge clk);
        check("en_busy_before", 32'(busy0), 1);
        en0 = 1'b0;
        @(negedge clk);
        check("en_busy_after", 32'(busy0), 0);
      end
    join
    en0 = 1'b1;
    drive(0, 1'b1, 4);
    check("en_discarded", 32'(valid0), 0);
    send(0, 8'h0F, 1'b0, 1'b1, 1'b1);
    expect0("en_f0f", 8'h0F, 1'b0);
    clear(0);
    drive(0, 1'b1, 4);
    d = 8'($urandom);
    send(0, d, 1'b0, 1'b0, 1'b1);
    expect0("brk", d, 1'b1);
    clear(0);
    busy_seen = 1'b0;
    drive(0, 1'b0, 64);
    check("brk_low_busy", 32'(busy_seen), 0);
    drive(0, 1'b1, 32);
    check("brk_no_retrigger", 32'(valid0), 0);
    send(0, 8'h81, 1'b0, 1'b1, 1'b1);
    expect0("pre_rst", 8'h81, 1'b0);
    fork
      send(0, 8'h00, 1'b0, 1'b1, 1'b1);
      begin
        repeat (80) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst0_outputs", 32'({busy0, valid0, fe0, pe0, ovr0, data0}), 0);
        check("midrst1_outputs", 32'({busy1, valid1, fe1, pe1, ovr1, data1}), 0);
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
